// File: rtl/uart_rx_deserializer_if.sv
// Received-frame bus from the UART RX deserializer to the register block.
interface uart_rx_deserializer_if #(
  parameter int MAX_FRAME_SIZE = 11
);
  logic [MAX_FRAME_SIZE-1:0] frame;
  logic                      parity_err;
  logic                      frame_err;
  logic                      output_valid;

  modport master (
    output frame,
    output parity_err,
    output frame_err,
    output output_valid
  );

  modport slave (
    input frame,
    input parity_err,
    input frame_err,
    input output_valid
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: line synchroniser, phase-accumulator bit timing and
// start/data/parity/stop deserialiser with parity and framing error reporting.
module uart_rx_deserializer #(
  parameter int MIN_FRAME_SIZE = 8,
  parameter int MAX_FRAME_SIZE = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [15:0]            cr_acc_incr_i,
  input  logic                   cr_ds_i,
  input  logic                   cr_s_i,
  input  logic [1:0]             cr_p_i,
  input  logic                   uart_rx_i,
  uart_rx_deserializer_if.master rx_out
);

  if (MIN_FRAME_SIZE > MAX_FRAME_SIZE) begin : g_bad_frame_size
    $error("MIN_FRAME_SIZE exceeds MAX_FRAME_SIZE");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic                      sync1_reg;
  logic                      rx_s_reg;
  logic                      rx_q_reg;
  logic [15:0]               acc_reg;
  logic [15:0]               acc_sum;
  logic                      tick;
  logic [3:0]                cnt_reg;
  logic [MAX_FRAME_SIZE-1:0] shift_reg;
  logic                      perr_reg;
  logic                      ferr_reg;
  logic [MAX_FRAME_SIZE-1:0] frame_reg;
  logic                      parity_err_reg;
  logic                      frame_err_reg;
  logic                      valid_reg;

  logic                      fall;
  logic                      has_par;
  logic [3:0]                data_last;
  logic [3:0]                stop_last;
  logic [MAX_FRAME_SIZE-1:0] bit_mask;
  logic [MAX_FRAME_SIZE-1:0] frame_next;

  logic acc_load;
  logic frame_clear;
  logic bit_store;
  logic par_chk;
  logic stop_chk;
  logic frame_done;

  assign fall    = rx_q_reg & ~rx_s_reg;
  assign {tick, acc_sum} = {1'b0, acc_reg} + {1'b0, cr_acc_incr_i};
  assign has_par = cr_p_i[1];

  // Frame positions: data first, then optional parity, then one or two stop bits.
  assign data_last  = cr_ds_i ? 4'd6 : 4'd7;
  assign stop_last  = data_last + 4'd1 + {3'b000, has_par} + {3'b000, cr_s_i};
  assign bit_mask   = {{(MAX_FRAME_SIZE-1){1'b0}}, rx_s_reg} << cnt_reg;
  assign frame_next = shift_reg | bit_mask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_reg <= 1'b1;
      rx_s_reg  <= 1'b1;
      rx_q_reg  <= 1'b1;
    end else begin
      sync1_reg <= uart_rx_i;
      rx_s_reg  <= sync1_reg;
      rx_q_reg  <= rx_s_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fall) state_next = START;
      START:   if (tick) state_next = rx_s_reg ? IDLE : DATA;
      DATA:    if (tick && cnt_reg == data_last) state_next = has_par ? PARITY : STOP;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick && cnt_reg == stop_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_load    = 1'b0;
    frame_clear = 1'b0;
    bit_store   = 1'b0;
    par_chk     = 1'b0;
    stop_chk    = 1'b0;
    frame_done  = 1'b0;
    case (state_reg)
      IDLE:   acc_load    = fall;
      START:  frame_clear = tick & ~rx_s_reg;
      DATA:   bit_store   = tick;
      PARITY: begin
        bit_store = tick;
        par_chk   = tick;
      end
      STOP: begin
        bit_store  = tick;
        stop_chk   = tick;
        frame_done = tick && (cnt_reg == stop_last);
      end
      default: ;
    endcase
  end

  // Preloading half a period puts the first tick in the middle of the start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_reg <= 16'h0000;
    end else if (acc_load) begin
      acc_reg <= 16'h8000;
    end else begin
      acc_reg <= acc_sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg   <= 4'd0;
      shift_reg <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else if (frame_clear) begin
      cnt_reg   <= 4'd0;
      shift_reg <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      if (bit_store) begin
        cnt_reg   <= cnt_reg + 4'd1;
        shift_reg <= frame_next;
      end
      // Only data bits are in the shift register when the parity bit is sampled.
      if (par_chk) begin
        perr_reg <= ((^shift_reg[7:0]) ^ rx_s_reg) != cr_p_i[0];
      end
      if (stop_chk && !rx_s_reg) begin
        ferr_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_reg      <= '0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      valid_reg <= frame_done;
      if (frame_done) begin
        frame_reg      <= frame_next;
        parity_err_reg <= perr_reg & has_par;
        frame_err_reg  <= ferr_reg | ~rx_s_reg;
      end
    end
  end

  assign rx_out.frame        = frame_reg;
  assign rx_out.parity_err   = parity_err_reg;
  assign rx_out.frame_err    = frame_err_reg;
  assign rx_out.output_valid = valid_reg;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clocks per bit (incr = 16'h1000).
module tb_uart_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] incr = 16'h1000;
  logic        ds = 1'b0;
  logic        s = 1'b0;
  logic [1:0]  p = 2'b00;
  logic        rx = 1'b1;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int base = 0;

  always #5 clk = ~clk;

  uart_rx_deserializer_if rx_if ();

  uart_rx_deserializer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cr_acc_incr_i (incr),
    .cr_ds_i       (ds),
    .cr_s_i        (s),
    .cr_p_i        (p),
    .uart_rx_i     (rx),
    .rx_out        (rx_if)
  );

  always @(negedge clk) begin
    if (rx_if.output_valid === 1'b1) strobes++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic line_bit(input logic v);
    #1 rx = v;
    repeat (16) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int nd, input logic has_par,
                      input logic pb, input logic stop_v, input int ns);
    line_bit(1'b0);
    for (int i = 0; i < nd; i++) line_bit(d[i]);
    if (has_par) line_bit(pb);
    for (int i = 0; i < ns; i++) line_bit(stop_v);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [10:0] f,
                              input logic pe, input logic fe);
    #2;
    check({tag, "_strobes"}, strobes - base, 1);
    check({tag, "_frame"}, rx_if.frame, f);
    check({tag, "_perr"}, rx_if.parity_err, pe);
    check({tag, "_ferr"}, rx_if.frame_err, fe);
    $display("frame %s: frame=%03h perr=%0d ferr=%0d", tag, rx_if.frame,
             rx_if.parity_err, rx_if.frame_err);
    base = strobes;
  endtask

  task automatic do_reset(input logic nds, input logic ns, input logic [1:0] np);
    #1 rst_n = 1'b0;
    ds = nds;
    s = ns;
    p = np;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    base = strobes;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_frame", rx_if.frame, 0);
    check("rst_perr", rx_if.parity_err, 0);
    check("rst_ferr", rx_if.frame_err, 0);
    check("rst_valid", rx_if.output_valid, 0);
    do_reset(1'b0, 1'b0, 2'b00);

    send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1);
    expect_frame("8n1_a5", 11'h1A5, 1'b0, 1'b0);

    send(8'h55, 8, 1'b0, 1'b0, 1'b0, 1);
    expect_frame("8n1_stop0", 11'h055, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    send(8'h00, 8, 1'b0, 1'b0, 1'b1, 1);
    expect_frame("8n1_00", 11'h100, 1'b0, 1'b0);

    // Short low glitch must be rejected as a false start.
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (16) @(posedge clk);
    #2 check("glitch_strobes", strobes - base, 0);
    send(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1);
    expect_frame("after_glitch", 11'h13C, 1'b0, 1'b0);

    // Break: exactly one errored all-zero frame while the line stays low.
    #1 rx = 1'b0;
    repeat (16 * 10 + 100) @(posedge clk);
    expect_frame("break", 11'h000, 1'b0, 1'b1);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    #2 check("break_extra", strobes - base, 0);
    send(8'h81, 8, 1'b0, 1'b0, 1'b1, 1);
    expect_frame("after_break", 11'h181, 1'b0, 1'b0);

    // Asynchronous reset after three data bits discards the frame.
    line_bit(1'b0);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    #1 rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("midrst_frame", rx_if.frame, 0);
    check("midrst_perr", rx_if.parity_err, 0);
    check("midrst_ferr", rx_if.frame_err, 0);
    check("midrst_valid", rx_if.output_valid, 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #2 check("midrst_strobes", strobes - base, 0);
    send(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1);
    expect_frame("after_midrst", 11'h1C3, 1'b0, 1'b0);

    do_reset(1'b0, 1'b0, 2'b10);
    send(8'h03, 8, 1'b1, 1'b0, 1'b1, 1);
    expect_frame("8e1_ok", 11'h203, 1'b0, 1'b0);
    send(8'h03, 8, 1'b1, 1'b1, 1'b1, 1);
    expect_frame("8e1_bad", 11'h303, 1'b1, 1'b0);

    do_reset(1'b1, 1'b1, 2'b11);
    send(8'h41, 7, 1'b1, 1'b1, 1'b1, 2);
    expect_frame("7o2_ok", 11'h3C1, 1'b0, 1'b0);
    send(8'h41, 7, 1'b1, 1'b0, 1'b1, 2);
    expect_frame("7o2_bad", 11'h341, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
